// File: rtl/sample_scheduler_pkg.sv
// Shared FSM encoding and constants for the sample scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
package sample_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STEP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOAD   = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    // Smallest usable period: guarantees a low cycle between `next` strobes.
    localparam int MIN_DIV = 2;

    // States in which a period wrap means the sample path fell behind.
    function automatic logic in_sample_path(input state_t s);
        return (s == ST_STEP) || (s == ST_SETTLE) || (s == ST_LOAD);
    endfunction

endpackage

// File: rtl/sample_scheduler_rate_divider.sv
// Free-running period counter 0..div-1; tick marks the last count of each period.
// Latency: tick is combinational from the counter; clear takes effect at the next edge.
// Backpressure: none; never pauses.
module sample_scheduler_rate_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == (div - DIV_W'(1)));
    assign tick = wrap && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/sample_scheduler.sv
// Issues `next` strobes at a programmable period and hands each sample to the DAC via req/ack.
// Latency: first `next` div_l cycles after start; dac_req SETTLE+1 cycles after each `next`.
// Backpressure: dac_req held until dac_ack; late periods collapse to one pending step (overrun).
// Optional SAMPLE_SCHED_ACK_TIMEOUT_EN adds a 1023-cycle ack timeout with sticky ack_err.
module sample_scheduler
    import sample_scheduler_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int BURST_W = 8,
    parameter int SETTLE  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_burst,
    input  logic [DIV_W-1:0]   divisor,
    input  logic [BURST_W-1:0] burst_len,
    output logic               next,
    output logic               dac_req,
    input  logic               dac_ack,
    output logic               busy,
    output logic               done,
    output logic               overrun
`ifdef SAMPLE_SCHED_ACK_TIMEOUT_EN
    ,
    output logic               ack_err
`endif
);

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_l;
    logic               mode_l;
    logic [BURST_W-1:0] burst_l;
    logic [BURST_W-1:0] step_cnt;
    logic [1:0]         settle_cnt;
    logic               pending;
    logic               stop_pend;
    logic               tick;
    logic               accept;
    logic               settle_done;
    logic               burst_end;
    logic               to_expire;
    logic               div_clear;

    assign accept      = (state == ST_IDLE) && start && !stop;
    assign settle_done = (settle_cnt == 2'(SETTLE - 1));
    assign burst_end   = mode_l && (step_cnt == burst_l);
    assign div_clear   = (state == ST_IDLE);

    sample_scheduler_rate_divider #(
        .DIV_W (DIV_W)
    ) u_rate_divider (
        .clk   (clk),
        .rst   (rst),
        .clear (div_clear),
        .div   (div_l),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        next      = 1'b0;
        dac_req   = 1'b0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (mode_burst && (burst_len == '0)) ? ST_FIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (stop) begin
                    state_nxt = ST_FIN;
                end else if (tick) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                next = 1'b1;
                if (stop) begin
                    state_nxt = ST_FIN;
                end else if (SETTLE == 0) begin
                    state_nxt = ST_LOAD;
                end else begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (stop) begin
                    state_nxt = ST_FIN;
                end else if (settle_done) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                dac_req = 1'b1;
                // A wrap in this very cycle counts as an expired period.
                if (dac_ack) begin
                    if (stop || stop_pend || burst_end) begin
                        state_nxt = ST_FIN;
                    end else if (pending || tick) begin
                        state_nxt = ST_STEP;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end else if (to_expire) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_l      <= '0;
            mode_l     <= 1'b0;
            burst_l    <= '0;
            step_cnt   <= '0;
            settle_cnt <= '0;
            pending    <= 1'b0;
            stop_pend  <= 1'b0;
            overrun    <= 1'b0;
        end else if (accept) begin
            div_l      <= (divisor < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : divisor;
            mode_l     <= mode_burst;
            burst_l    <= burst_len;
            step_cnt   <= '0;
            settle_cnt <= '0;
            pending    <= 1'b0;
            stop_pend  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (state == ST_STEP) begin
                step_cnt <= step_cnt + BURST_W'(1);
            end
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 2'd1 : 2'd0;
            // Only one missed period is remembered; further wraps are dropped.
            if (state_nxt == ST_STEP) begin
                pending <= 1'b0;
            end else if (tick && in_sample_path(state)) begin
                pending <= 1'b1;
            end
            if (tick && in_sample_path(state)) begin
                overrun <= 1'b1;
            end
            if (state == ST_LOAD) begin
                if (stop) begin
                    stop_pend <= 1'b1;
                end
            end else begin
                stop_pend <= 1'b0;
            end
        end
    end

`ifdef SAMPLE_SCHED_ACK_TIMEOUT_EN
    logic [9:0] to_cnt;

    assign to_expire = (state == ST_LOAD) && (to_cnt == 10'd1022);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            ack_err <= 1'b0;
        end else begin
            to_cnt <= (state == ST_LOAD) ? to_cnt + 10'd1 : 10'd0;
            if (accept) begin
                ack_err <= 1'b0;
            end else if (to_expire && !dac_ack) begin
                ack_err <= 1'b1;
            end
        end
    end
`else
    assign to_expire = 1'b0;
`endif

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed playback vectors plus hand-written stop/reset sequences for sample_scheduler.
module tb_sample_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, mode_burst;
    logic [15:0] divisor;
    logic [7:0]  burst_len;
    logic        next, dac_req, dac_ack, busy, done, overrun;
`ifdef SAMPLE_SCHED_ACK_TIMEOUT_EN
    logic        ack_err;
`endif

    int n_vec  = 0;
    int n_fail = 0;
    int ack_dly = 0;
    int req_age = 0;

    always #5 clk = ~clk;

    sample_scheduler #(
        .DIV_W   (16),
        .BURST_W (8),
        .SETTLE  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode_burst (mode_burst),
        .divisor    (divisor),
        .burst_len  (burst_len),
        .next       (next),
        .dac_req    (dac_req),
        .dac_ack    (dac_ack),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
`ifdef SAMPLE_SCHED_ACK_TIMEOUT_EN
        ,
        .ack_err    (ack_err)
`endif
    );

    typedef struct {
        int div;
        bit mode;
        int blen;
        int ack_dly;
        int ncyc;
        int e_n_next;
        int e_first;
        int e_second;
        int e_gap;
        int e_req_w;
        int e_done;
        int e_ov;
        int e_busy;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string tag, input string what, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0d expected %0d", tag, what, act, exp);
        end
    endtask

    // Advance to the next falling edge and answer dac_req after ack_dly cycles.
    task automatic cycle();
        @(negedge clk);
        if (dac_req) begin
            dac_ack = (req_age >= ack_dly);
            req_age++;
        end else begin
            dac_ack = 1'b0;
            req_age = 0;
        end
    endtask

    task automatic launch(input int div, input bit mode, input int blen, input bit stp);
        cycle();
        divisor    = 16'(div);
        mode_burst = mode;
        burst_len  = 8'(blen);
        start      = 1'b1;
        stop       = stp;
        cycle();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n_next, first, second, first_req, cur_w, max_w, done_cyc, busy_after, gap;
        n_next = 0; first = -1; second = -1; first_req = -1;
        cur_w = 0; max_w = 0; done_cyc = -1; busy_after = -1;
        ack_dly = v.ack_dly;
        launch(v.div, v.mode, v.blen, 1'b0);
        for (int k = 0; k < v.ncyc; k++) begin
            if (k > 0) cycle();
            if (next) begin
                n_next++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (dac_req) begin
                cur_w++;
                if (first_req < 0) first_req = k;
            end else begin
                cur_w = 0;
            end
            if (cur_w > max_w) max_w = cur_w;
            if (done && done_cyc < 0) done_cyc = k;
            if (done_cyc >= 0 && k == done_cyc + 1) busy_after = int'(busy);
        end
        gap = (first >= 0 && first_req >= 0) ? first_req - first : -1;
        chk(tag, "n_next",   n_next,       v.e_n_next);
        chk(tag, "first",    first,        v.e_first);
        chk(tag, "second",   second,       v.e_second);
        chk(tag, "req_gap",  gap,          v.e_gap);
        chk(tag, "req_w",    max_w,        v.e_req_w);
        chk(tag, "done_cyc", done_cyc,     v.e_done);
        chk(tag, "overrun",  int'(overrun), v.e_ov);
        chk(tag, "busy_end", int'(busy),   v.e_busy);
        if (done_cyc >= 0) chk(tag, "busy_after_done", busy_after, 0);
        if (busy) begin
            stop = 1'b1;
            cycle();
            stop = 1'b0;
            for (int i = 0; i < 30 && busy; i++) cycle();
        end
        chk(tag, "idle_after_cleanup", int'(busy), 0);
        ack_dly = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        //       div mode blen ack  ncyc  n  first sec gap w  done ov busy
        vt[0] = '{4,   0,   0,   0,  20,   4,  4,   8,  2, 1,  -1, 0, 1};
        vt[1] = '{5,   1,   3,   0,  25,   3,  5,  10,  2, 1,  18, 0, 0};
        vt[2] = '{3,   0,   0,   6,  16,   2,  3,  12,  2, 7,  -1, 1, 1};
        vt[3] = '{0,   1,   2,   0,  12,   2,  2,   5,  2, 1,   8, 1, 0};
        vt[4] = '{1,   1,   1,   0,  10,   1,  2,  -1,  2, 1,   5, 1, 0};
        vt[5] = '{4,   1,   0,   0,   6,   0, -1,  -1, -1, 0,   0, 0, 0};
        vt[6] = '{4,   1,   1,   2,  14,   1,  4,  -1,  2, 3,   9, 1, 0};
        vt[7] = '{6,   0,   0,   1,  15,   2,  6,  12,  2, 2,  -1, 0, 1};
        vt[8] = '{2,   0,   0,   0,   9,   3,  2,   5,  2, 1,  -1, 1, 1};
        vt[9] = '{2,   1, 255,   0, 800, 255,  2,   5,  2, 1, 767, 1, 0};

        rst = 1'b1; start = 1'b0; stop = 1'b0; mode_burst = 1'b0;
        divisor = '0; burst_len = '0; dac_ack = 1'b0;
        #12;
        chk("reset", "outputs", int'({next, dac_req, busy, done, overrun}), 0);
        cycle();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        // Stop while a handshake is pending: req held until ack, then done.
        ack_dly = 2;
        launch(4, 1'b0, 0, 1'b0);
        repeat (6) cycle();
        chk("stop_load", "req_c6", int'(dac_req), 1);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        chk("stop_load", "req_c7", int'(dac_req), 1);
        cycle();
        chk("stop_load", "req_c8", int'(dac_req), 1);
        cycle();
        chk("stop_load", "done_c9", int'(done), 1);
        chk("stop_load", "req_c9", int'(dac_req), 0);
        cycle();
        chk("stop_load", "busy_c10", int'(busy), 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            cnt += int'(next);
        end
        chk("stop_load", "late_next", cnt, 0);
        ack_dly = 0;

        // Start and stop together: nothing happens.
        launch(4, 1'b0, 0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cnt += int'(busy) + int'(done) + int'(next);
            cycle();
        end
        chk("start_stop", "activity", cnt, 0);

        // Reset while waiting for the first period.
        launch(5, 1'b0, 0, 1'b0);
        repeat (2) cycle();
        chk("rst_wait", "busy_before", int'(busy), 1);
        #2 rst = 1'b1;
        #1 chk("rst_wait", "outputs", int'({next, dac_req, busy, done, overrun}), 0);
        cycle();
        rst = 1'b0;
        run_vec('{5, 1, 1, 0, 12, 1, 5, -1, 2, 1, 8, 0, 0}, "rst_wait_restart");

        // Reset in the middle of a stalled handshake.
        ack_dly = 100;
        launch(4, 1'b0, 0, 1'b0);
        repeat (8) cycle();
        chk("rst_load", "req_ov_before", int'({dac_req, overrun}), 3);
        #2 rst = 1'b1;
        #1 chk("rst_load", "outputs", int'({next, dac_req, busy, done, overrun}), 0);
        cycle();
        rst = 1'b0;
        ack_dly = 0;
        run_vec('{4, 1, 2, 0, 14, 2, 4, 8, 2, 1, 11, 0, 0}, "rst_load_restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
